// File: rtl/axis_dac_cmd_decoder_pkg.sv
// Shared constants, state encoding and slot layout for the AXIS DAC command decoder.
package dac_cmd_pkg;

    localparam int SLOT_W    = 24;
    localparam int NUM_SLOTS = 3;
    localparam int WORD_W    = SLOT_W * NUM_SLOTS;
    localparam int DATA_W    = 16;

    localparam logic [1:0] LAST_SLOT = 2'(NUM_SLOTS - 1);

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_SET_A  = 8'h11;
    localparam logic [7:0] OP_SET_B  = 8'h14;
    localparam logic [7:0] OP_COMMIT = 8'h25;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HOLD
    } state_t;

    typedef struct packed {
        logic [7:0]        opcode;
        logic [DATA_W-1:0] data;
    } slot_t;

    function automatic slot_t get_slot(input logic [WORD_W-1:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    get_slot = slot_t'(word[SLOT_W-1:0]);
            2'd1:    get_slot = slot_t'(word[2*SLOT_W-1:SLOT_W]);
            2'd2:    get_slot = slot_t'(word[3*SLOT_W-1:2*SLOT_W]);
            default: get_slot = '0;
        endcase
    endfunction

endpackage

// File: rtl/axis_dac_cmd_decoder_hold_timer.sv
// Post-commit hold counter: loads the COMMIT data, counts down while enabled,
// and flags the final hold cycle.
module dac_cmd_hold_timer
    import dac_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_val,
    input  logic              i_dec,
    output logic              o_done
);

    logic [DATA_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - DATA_W'(1);
        end
    end

    // Done on the value 1 so a hold of N occupies exactly N cycles.
    assign o_done = (r_count == DATA_W'(1));

endmodule

// File: rtl/axis_dac_cmd_decoder.sv
// Executes three {opcode,data} slots per 72-bit AXIS word into a dual-channel DAC register pair.
// Optional macro AXIS_DAC_CMD_DECODER_ERRCNT_EN adds a saturating err_count output.
module axis_dac_cmd_decoder
    import dac_cmd_pkg::*;
(
    input  logic              aclk,
    input  logic              areset,
    input  logic [WORD_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] dac_a_data,
    output logic [DATA_W-1:0] dac_b_data,
    output logic              dac_update,
    output logic              cmd_error,
`ifdef AXIS_DAC_CMD_DECODER_ERRCNT_EN
    output logic [15:0]       err_count,
`endif
    output logic              busy
);

    state_t            r_state;
    state_t            w_next;
    logic [WORD_W-1:0] r_word;
    logic [1:0]        r_slot;
    logic [DATA_W-1:0] r_sh_a;
    logic [DATA_W-1:0] r_sh_b;
    logic [DATA_W-1:0] r_dac_a;
    logic [DATA_W-1:0] r_dac_b;
    logic              r_upd;
    logic              r_err;
    logic              r_ready;
    slot_t             w_cur;
    logic              w_accept;
    logic              w_exec;
    logic              w_hold_load;
    logic              w_hold_dec;
    logic              w_hold_done;

    assign w_cur = get_slot(r_word, r_slot);

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        w_hold_load = 1'b0;
        w_hold_dec  = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_axis_tvalid && r_ready) begin
                    w_accept = 1'b1;
                    w_next   = EXEC;
                end
            end
            EXEC: begin
                w_exec = 1'b1;
                if ((w_cur.opcode == OP_COMMIT) && (w_cur.data != '0)) begin
                    w_hold_load = 1'b1;
                    w_next      = HOLD;
                end else if (r_slot == LAST_SLOT) begin
                    w_next = IDLE;
                end
            end
            HOLD: begin
                w_hold_dec = 1'b1;
                // r_slot already points past the COMMIT; past the last slot means the word is done.
                if (w_hold_done) begin
                    w_next = (r_slot > LAST_SLOT) ? IDLE : EXEC;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_word  <= '0;
            r_slot  <= '0;
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_dac_a <= '0;
            r_dac_b <= '0;
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_upd   <= 1'b0;
            r_err   <= 1'b0;
            r_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_word <= s_axis_tdata;
                r_slot <= '0;
            end
            if (w_exec) begin
                r_slot <= r_slot + 2'd1;
                case (w_cur.opcode)
                    OP_NOP:   begin end
                    OP_SET_A: r_sh_a <= w_cur.data;
                    OP_SET_B: r_sh_b <= w_cur.data;
                    OP_COMMIT: begin
                        r_dac_a <= r_sh_a;
                        r_dac_b <= r_sh_b;
                        r_upd   <= 1'b1;
                    end
                    default:  r_err <= 1'b1;
                endcase
            end
        end
    end

    dac_cmd_hold_timer u_hold_timer (
        .clk        (aclk),
        .rst        (areset),
        .i_load     (w_hold_load),
        .i_load_val (w_cur.data),
        .i_dec      (w_hold_dec),
        .o_done     (w_hold_done)
    );

`ifdef AXIS_DAC_CMD_DECODER_ERRCNT_EN
    logic [15:0] r_errcnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_errcnt <= '0;
        end else if (w_exec && (w_cur.opcode != OP_NOP) && (w_cur.opcode != OP_SET_A) &&
                     (w_cur.opcode != OP_SET_B) && (w_cur.opcode != OP_COMMIT) &&
                     (r_errcnt != '1)) begin
            r_errcnt <= r_errcnt + 16'd1;
        end
    end

    assign err_count = r_errcnt;
`endif

    assign s_axis_tready = r_ready;
    assign dac_a_data    = r_dac_a;
    assign dac_b_data    = r_dac_b;
    assign dac_update    = r_upd;
    assign cmd_error     = r_err;
    assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_axis_dac_cmd_decoder.sv
// Self-checking bench for axis_dac_cmd_decoder: directed table, corner sequences and a
// randomized run checked every cycle against a slot-timeline reference model.
module tb_axis_dac_cmd_decoder;

    logic        aclk = 1'b0;
    logic        areset;
    logic [71:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [15:0] dac_a_data;
    logic [15:0] dac_b_data;
    logic        dac_update;
    logic        cmd_error;
    logic        busy;
`ifdef AXIS_DAC_CMD_DECODER_ERRCNT_EN
    logic [15:0] err_count;
`endif

    axis_dac_cmd_decoder dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .dac_a_data    (dac_a_data),
        .dac_b_data    (dac_b_data),
        .dac_update    (dac_update),
        .cmd_error     (cmd_error),
`ifdef AXIS_DAC_CMD_DECODER_ERRCNT_EN
        .err_count     (err_count),
`endif
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: each accepted word becomes a timeline of events keyed by edge number.
    logic [15:0] m_sh_a, m_sh_b, m_out_a, m_out_b, m_errcnt;
    int          m_ready_at;
    logic [15:0] ev_a[int];
    logic [15:0] ev_b[int];
    bit          ev_err[int];
    logic        dut_hs;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (edge %0d): got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset(input int e);
        m_sh_a   = '0;
        m_sh_b   = '0;
        m_out_a  = '0;
        m_out_b  = '0;
        m_errcnt = '0;
        ev_a.delete();
        ev_b.delete();
        ev_err.delete();
        m_ready_at = e + 1;
    endfunction

    // Slot k lands o edges after accept; a COMMIT with data N pushes later slots back N edges.
    function automatic void model_accept(input logic [71:0] w, input int a);
        int          o = 1;
        logic [7:0]  op;
        logic [15:0] d;
        for (int k = 0; k < 3; k++) begin
            op = w[24*k+16 +: 8];
            d  = w[24*k +: 16];
            case (op)
                8'h00: begin end
                8'h11: m_sh_a = d;
                8'h14: m_sh_b = d;
                8'h25: begin
                    ev_a[a+o] = m_sh_a;
                    ev_b[a+o] = m_sh_b;
                    o += int'(d);
                end
                default: ev_err[a+o] = 1'b1;
            endcase
            o++;
        end
        m_ready_at = a + o - 1;
    endfunction

    task automatic tick(input logic rst, input logic vld, input logic [71:0] d, output logic acc);
        logic exp_rdy, exp_upd, exp_err;
        areset        = rst;
        s_axis_tvalid = vld;
        s_axis_tdata  = d;
        dut_hs        = vld && s_axis_tready && !rst;
        @(posedge aclk);
        cyc++;
        acc = 1'b0;
        if (rst) begin
            model_reset(cyc);
        end else if (vld && ((cyc - 1) >= m_ready_at)) begin
            acc = 1'b1;
            model_accept(d, cyc);
        end
        #1;
        exp_upd = ev_a.exists(cyc) ? 1'b1 : 1'b0;
        if (exp_upd) begin
            m_out_a = ev_a[cyc];
            m_out_b = ev_b[cyc];
            ev_a.delete(cyc);
            ev_b.delete(cyc);
        end
        exp_err = ev_err.exists(cyc) ? 1'b1 : 1'b0;
        if (exp_err) begin
            ev_err.delete(cyc);
            if (m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
        end
        exp_rdy = (cyc >= m_ready_at);
        chk("tready", 32'(s_axis_tready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(!exp_rdy && !rst));
        chk("dac_update", 32'(dac_update), 32'(exp_upd));
        chk("cmd_error", 32'(cmd_error), 32'(exp_err));
        chk("dac_a_data", 32'(dac_a_data), 32'(m_out_a));
        chk("dac_b_data", 32'(dac_b_data), 32'(m_out_b));
`ifdef AXIS_DAC_CMD_DECODER_ERRCNT_EN
        chk("err_count", 32'(err_count), 32'(m_errcnt));
`endif
    endtask

    function automatic logic [71:0] rand_word();
        logic [71:0] w;
        logic [7:0]  op;
        logic [15:0] d;
        int          r;
        for (int k = 0; k < 3; k++) begin
            r = int'($urandom_range(0, 9));
            d = 16'($urandom);
            if (r < 2)      op = 8'h00;
            else if (r < 4) op = 8'h11;
            else if (r < 6) op = 8'h14;
            else if (r < 8) op = 8'h25;
            else            op = 8'($urandom);
            if (op == 8'h25)
                d = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(4, 40)) : 16'($urandom_range(0, 3));
            w[24*k +: 24] = {op, d};
        end
        return w;
    endfunction

    typedef struct {
        logic [71:0] word;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int          n_upd;
        int          n_err;
        int          upd_off;
        int          err_off;
        int          rdy_off;
        int          errcnt;
    } vec_t;

    vec_t vec[6];

    initial begin
        logic        acc, pend;
        logic [71:0] w;
        logic [71:0] bw[3];
        int          t0, n_u, n_e, fu, fe, rdy, n_hs, last;

        vec[0] = '{72'h25_0000_14_BEEF_11_1234, 16'h1234, 16'hBEEF, 1, 0, 3, -1, 3, 0};
        vec[1] = '{72'h25_0003_14_0002_11_0001, 16'h0001, 16'h0002, 1, 0, 3, -1, 6, 0};
        vec[2] = '{72'h00_0000_7F_5555_11_AAAA, 16'h0001, 16'h0002, 0, 1, -1, 2, 3, 1};
        vec[3] = '{72'h25_0000_00_0000_00_0000, 16'hAAAA, 16'h0002, 1, 0, 3, -1, 3, 1};
        vec[4] = '{72'h25_0000_11_0077_25_0000, 16'h0077, 16'h0002, 2, 0, 1, -1, 3, 1};
        vec[5] = '{72'h25_0000_14_0099_25_0002, 16'h0077, 16'h0099, 2, 0, 1, -1, 5, 1};
        bw[0]  = 72'h25_0000_14_0B01_11_0A01;
        bw[1]  = 72'h25_0000_14_0B02_11_0A02;
        bw[2]  = 72'h25_0000_14_0B03_11_0A03;

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_ready_at    = 1 << 30;

        // Reset and release
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0, acc);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_dac_a", 32'(dac_a_data), 32'd0);
        chk("rst_dac_b", 32'(dac_b_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick(1'b0, 1'b0, '0, acc);
        chk("release_tready", 32'(s_axis_tready), 32'd1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) tick(1'b0, 1'b1, vec[i].word, acc);
            chk("tbl_accept", 32'(acc), 32'd1);
            t0 = cyc; n_u = 0; n_e = 0; fu = -1; fe = -1; rdy = -1;
            for (int t = 0; t < 12; t++) begin
                tick(1'b0, 1'b0, '0, acc);
                if (dac_update) begin n_u++; if (fu < 0) fu = cyc - t0; end
                if (cmd_error)  begin n_e++; if (fe < 0) fe = cyc - t0; end
                if (s_axis_tready && rdy < 0) rdy = cyc - t0;
            end
            chk("tbl_dac_a", 32'(dac_a_data), 32'(vec[i].exp_a));
            chk("tbl_dac_b", 32'(dac_b_data), 32'(vec[i].exp_b));
            chk("tbl_n_update", 32'(n_u), 32'(vec[i].n_upd));
            chk("tbl_n_error", 32'(n_e), 32'(vec[i].n_err));
            chk("tbl_update_offset", 32'(fu), 32'(vec[i].upd_off));
            chk("tbl_error_offset", 32'(fe), 32'(vec[i].err_off));
            chk("tbl_ready_offset", 32'(rdy), 32'(vec[i].rdy_off));
`ifdef AXIS_DAC_CMD_DECODER_ERRCNT_EN
            chk("tbl_err_count", 32'(err_count), 32'(vec[i].errcnt));
`endif
        end

        // Back-to-back words with tvalid held high
        n_hs = 0; n_u = 0; last = -1;
        begin
            int j = 0;
            for (int c = 0; c < 40 && j < 3; c++) begin
                tick(1'b0, 1'b1, bw[j], acc);
                if (dut_hs) begin
                    if (n_hs > 0) chk("b2b_gap", 32'(cyc - last), 32'd4);
                    last = cyc;
                    n_hs++;
                end
                if (dac_update) n_u++;
                if (acc) j++;
            end
        end
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 1'b0, '0, acc);
            if (dac_update) n_u++;
        end
        chk("b2b_handshakes", 32'(n_hs), 32'd3);
        chk("b2b_updates", 32'(n_u), 32'd3);
        chk("b2b_dac_a", 32'(dac_a_data), 32'h0A03);
        chk("b2b_dac_b", 32'(dac_b_data), 32'h0B03);

        // Reset two edges into a word
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) tick(1'b0, 1'b1, vec[0].word, acc);
        chk("midrst_accept", 32'(acc), 32'd1);
        n_u = 0;
        tick(1'b0, 1'b0, '0, acc); if (dac_update) n_u++;
        tick(1'b1, 1'b0, '0, acc); if (dac_update) n_u++;
        tick(1'b1, 1'b0, '0, acc); if (dac_update) n_u++;
        tick(1'b0, 1'b0, '0, acc); if (dac_update) n_u++;
        chk("midrst_tready", 32'(s_axis_tready), 32'd1);
        chk("midrst_dac_a", 32'(dac_a_data), 32'd0);
        chk("midrst_dac_b", 32'(dac_b_data), 32'd0);
        for (int t = 0; t < 4; t++) begin
            tick(1'b0, 1'b0, '0, acc);
            if (dac_update) n_u++;
        end
        chk("midrst_no_update", 32'(n_u), 32'd0);
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) tick(1'b0, 1'b1, vec[3].word, acc);
        n_u = 0;
        for (int t = 0; t < 6; t++) begin
            tick(1'b0, 1'b0, '0, acc);
            if (dac_update) n_u++;
        end
        chk("midrst_commit_updates", 32'(n_u), 32'd1);
        chk("midrst_shadow_a", 32'(dac_a_data), 32'd0);
        chk("midrst_shadow_b", 32'(dac_b_data), 32'd0);

        // Maximum hold: COMMIT in slot 0 with data 0xFFFF
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) tick(1'b0, 1'b1, 72'h00_0000_00_0000_25_FFFF, acc);
        t0 = cyc; rdy = -1;
        for (int t = 0; t < 70000 && rdy < 0; t++) begin
            tick(1'b0, 1'b0, '0, acc);
            if (s_axis_tready) rdy = cyc - t0;
        end
        chk("max_hold_ready_offset", 32'(rdy), 32'd65538);

        // Randomized traffic with occasional resets
        pend = 1'b0;
        w    = '0;
        for (int it = 0; it < 1500; it++) begin
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                w    = rand_word();
                pend = 1'b1;
            end
            tick(($urandom_range(0, 99) == 0), pend, w, acc);
            if (acc) pend = 1'b0;
        end
        for (int t = 0; t < 60; t++) tick(1'b0, 1'b0, '0, acc);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
